// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU accumulator drain / requantization path.
package npu_pkg;

  localparam int ACC_W = 20;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;
  localparam int INT4_MIN = -8;
  localparam int INT4_MAX = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_t;

  localparam round_mode_t REQUANT_ROUND = RND_HALF_UP;

endpackage

// File: rtl/requant_lane.sv
// Combinational requantizer: round, arithmetic shift, add zero point, clamp
// into a signed OUT_W-bit result (OUT_W is 8 or 4).
module requant_lane
  import npu_pkg::*;
#(
  parameter int IN_W  = 37,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  prod,
  input  logic [4:0]       shift,
  input  logic [OUT_W-1:0] zp,
  output logic [OUT_W-1:0] y
);

  // Internal width covers a 31-bit rounding bias even for narrow products.
  localparam int SW      = ((IN_W > 32) ? IN_W : 32) + 2;
  localparam int OUT_MIN = (OUT_W == 4) ? INT4_MIN : INT8_MIN;
  localparam int OUT_MAX = (OUT_W == 4) ? INT4_MAX : INT8_MAX;
  localparam logic signed [SW-1:0] LO_LIM = SW'(OUT_MIN);
  localparam logic signed [SW-1:0] HI_LIM = SW'(OUT_MAX);

  logic signed [SW-1:0] p_ext;
  logic signed [SW-1:0] bias;
  logic signed [SW-1:0] rounded;
  logic signed [SW-1:0] shifted;
  logic signed [SW-1:0] zp_ext;
  logic signed [SW-1:0] offset;

  // Round-half-up, shift, offset and saturate.
  always_comb begin
    p_ext  = $signed({{(SW-IN_W){prod[IN_W-1]}}, prod});
    zp_ext = $signed({{(SW-OUT_W){zp[OUT_W-1]}}, zp});
    bias   = '0;
    if (REQUANT_ROUND == RND_HALF_UP && shift != 5'd0) begin
      bias = SW'(1) << (shift - 5'd1);
    end
    rounded = p_ext + bias;
    shifted = rounded >>> shift;
    offset  = shifted + zp_ext;
    if (offset > HI_LIM) begin
      y = HI_LIM[OUT_W-1:0];
    end else if (offset < LO_LIM) begin
      y = LO_LIM[OUT_W-1:0];
    end else begin
      y = offset[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_requant_drain.sv
// Snapshots one row of MAC accumulators, clears the MACs, and streams one
// requantized byte per column (INT8 or packed dual INT4) over valid/ready.
//
// state | meaning
// IDLE  | waiting for i_start; config and row are latched on start
// DRAIN | issuing columns 0..NUM_COLS-1 into the two-stage pipeline
// FLUSH | waiting for the last beat to be accepted, then pulse o_done
module acc_requant_drain
  import npu_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int ACC_W    = npu_pkg::ACC_W,
  parameter int SCALE_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_start,
  input  logic [NUM_COLS*ACC_W-1:0]   i_acc_vec,
  input  logic                        i_int4_mode,
  input  logic [SCALE_W-1:0]          i_scale,
  input  logic [4:0]                  i_shift,
  input  logic [7:0]                  i_zero_point,
  output logic                        o_clear_acc,
  output logic                        o_busy,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [7:0]                  o_data,
  output logic [$clog2(NUM_COLS)-1:0] o_col_idx,
  output logic                        o_last,
  output logic                        o_done
);

  localparam int CW   = $clog2(NUM_COLS);
  localparam int HW   = ACC_W / 2;
  localparam int P8W  = ACC_W + SCALE_W + 1;
  localparam int P4W  = HW + SCALE_W + 1;
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

  drain_state_t state, next_state;

  logic [NUM_COLS*ACC_W-1:0] acc_q;
  logic                      mode_q;
  logic [SCALE_W-1:0]        scale_q;
  logic [4:0]                shift_q;
  logic [7:0]                zp_q;
  logic [CW-1:0]             col_q;

  logic                  a_valid;
  logic [CW-1:0]         a_col;
  logic                  a_last;
  logic signed [P8W-1:0] a_p8;
  logic signed [P4W-1:0] a_phi;
  logic signed [P4W-1:0] a_plo;

  logic                  advance;
  logic                  start_ok;
  logic                  issue;
  logic                  last_accept;
  logic [ACC_W-1:0]      col_acc;
  logic signed [P8W-1:0] p8;
  logic signed [P4W-1:0] phi;
  logic signed [P4W-1:0] plo;
  logic [7:0]            y8;
  logic [3:0]            y_hi;
  logic [3:0]            y_lo;

  assign advance = !o_valid || i_ready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_start) next_state = DRAIN;
      DRAIN:   if (issue && col_q == LAST_COL) next_state = FLUSH;
      FLUSH:   if (last_accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    start_ok    = 1'b0;
    issue       = 1'b0;
    last_accept = 1'b0;
    o_busy      = 1'b0;
    case (state)
      IDLE:  start_ok = i_start;
      DRAIN: begin
        o_busy = 1'b1;
        issue  = advance;
      end
      FLUSH: begin
        o_busy      = 1'b1;
        last_accept = o_valid && o_last && i_ready;
      end
      default: ;
    endcase
  end

  // Row snapshot, frozen config, column counter and control pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      mode_q      <= 1'b0;
      scale_q     <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      col_q       <= '0;
      o_clear_acc <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      if (start_ok) begin
        acc_q   <= i_acc_vec;
        mode_q  <= i_int4_mode;
        scale_q <= i_scale;
        shift_q <= i_shift;
        zp_q    <= i_zero_point;
        col_q   <= '0;
      end else if (issue) begin
        col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
      end
      o_clear_acc <= start_ok;
      o_done      <= last_accept;
    end
  end

  // Column select and the three products (full INT8, INT4 high and low halves).
  always_comb begin
    col_acc = acc_q[col_q*ACC_W +: ACC_W];
    p8  = P8W'($signed(col_acc)) * P8W'($signed({1'b0, scale_q}));
    phi = P4W'($signed(col_acc[ACC_W-1:HW])) * P4W'($signed({1'b0, scale_q}));
    plo = P4W'($signed(col_acc[HW-1:0])) * P4W'($signed({1'b0, scale_q}));
  end

  // Stage A: multiply register.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_col   <= '0;
      a_last  <= 1'b0;
      a_p8    <= '0;
      a_phi   <= '0;
      a_plo   <= '0;
    end else if (advance) begin
      a_valid <= issue;
      if (issue) begin
        a_col  <= col_q;
        a_last <= (col_q == LAST_COL);
        a_p8   <= p8;
        a_phi  <= phi;
        a_plo  <= plo;
      end
    end
  end

  requant_lane #(.IN_W(P8W), .OUT_W(8)) u_lane_int8 (
    .prod  (a_p8),
    .shift (shift_q),
    .zp    (zp_q),
    .y     (y8)
  );

  requant_lane #(.IN_W(P4W), .OUT_W(4)) u_lane_hi (
    .prod  (a_phi),
    .shift (shift_q),
    .zp    (zp_q[3:0]),
    .y     (y_hi)
  );

  requant_lane #(.IN_W(P4W), .OUT_W(4)) u_lane_lo (
    .prod  (a_plo),
    .shift (shift_q),
    .zp    (zp_q[3:0]),
    .y     (y_lo)
  );

  // Stage B: requantized output register; holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_col_idx <= '0;
      o_last    <= 1'b0;
    end else if (advance) begin
      o_valid <= a_valid;
      if (a_valid) begin
        o_data    <= mode_q ? {y_hi, y_lo} : y8;
        o_col_idx <= a_col;
        o_last    <= a_last;
      end
    end
  end

endmodule

// File: doc/acc_requant_drain.md
# acc_requant_drain

Drain and requantize stage directly downstream of the systolic MAC array. On a start pulse it snapshots one row of `NUM_COLS` 20-bit accumulators, pulses `o_clear_acc` back to the MACs, and streams out one requantized byte per column over a valid/ready interface. Each byte is INT8, or a packed pair of INT4 values in dual mode. Its output feeds the activation buffer writer.

## Interface
- `NUM_COLS`, default 4: accumulators per row and beats per drain.
- `ACC_W`, default 20: accumulator width. Must be even; INT4 halves are `ACC_W/2`.
- `SCALE_W`, default 16: unsigned scale multiplier width.
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `i_start`  in  1  snapshot request. Sampled only in IDLE.
- `i_acc_vec`  in  `NUM_COLS*ACC_W`  accumulators; column c is bits `[c*ACC_W +: ACC_W]`.
- `i_int4_mode`  in  1  0 = INT8 requant, 1 = dual INT4 requant.
- `i_scale`  in  `SCALE_W`  unsigned multiplier.
- `i_shift`  in  5  right-shift amount, 0..31.
- `i_zero_point`  in  8  signed output offset. In INT4 mode only bits [3:0] are used, signed.
- `o_clear_acc`  out  1  one-cycle pulse to the MAC `clear_acc`.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  consumer accepts the beat.
- `o_data`  out  8  requantized byte.
- `o_col_idx`  out  `$clog2(NUM_COLS)`  column index of the current beat.
- `o_last`  out  1  current beat is column `NUM_COLS-1`.
- `o_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States:
  - IDLE: `i_start` moves to DRAIN and latches `i_acc_vec`, mode, scale, shift and zero point. Config stays frozen until the drain ends.
  - DRAIN: issues columns 0..`NUM_COLS-1` into the pipeline. Moves to FLUSH after the last issue.
  - FLUSH: waits for the last beat to be accepted, then pulses `o_done` and returns to IDLE.
- INT8 per column:
  - p = acc × scale, signed × unsigned, 37-bit signed.
  - r = (p + (shift ? 1<<(shift−1) : 0)) >>> shift, arithmetic shift (round-half-up).
  - y = r + zp.
  - Clamp y to [−128, 127].
- INT4 per column:
  - Split acc into hi = acc[19:10] and lo = acc[9:0], each signed 10-bit.
  - Apply the same equation to each half with a 4-bit zp.
  - Clamp each result to [−8, 7].
  - `o_data` = {hi4, lo4}.
- `i_start` while busy: ignored.
- Stall: the whole pipeline advances only when `!o_valid || i_ready`. No beats are dropped or reordered.
- Reset outputs: `o_valid`, `o_clear_acc`, `o_busy`, `o_done`, `o_last` = 0; `o_data` = 0; `o_col_idx` = 0; state = IDLE.
- Reset mid-drain: the row is abandoned. `o_valid` is 0 the cycle after reset is sampled, and no `o_done` is issued.

## Timing
- Pipeline stages:
  - Stage A: multiply register.
  - Stage B: round, shift, offset and clamp into the output register.
- `i_start` sampled high in cycle T:
  - `o_clear_acc` is high in T+1 only. The snapshot in T precedes the MAC's synchronous clear.
  - `o_busy` is high from T+1.
  - First `o_valid` is in T+3.
- With `i_ready` held high: one beat per cycle.
  - Column `NUM_COLS-1` is in T+2+`NUM_COLS` with `o_last`=1.
  - `o_done` is in the following cycle, where `o_busy` also drops.
- While `o_valid`=1 and `i_ready`=0, `o_data`, `o_col_idx` and `o_last` hold stable.
- Earliest next start: `i_start` is accepted in the same cycle `o_done` is high (state is IDLE then).

## Structure
- Shared package `npu_pkg` holds:
  - `ACC_W`.
  - INT8/INT4 min/max constants.
  - the state enum `drain_state_t` {IDLE, DRAIN, FLUSH}.
  - the requant rounding-mode constant.
- One sub-module, `requant_lane`: combinational round/shift/offset/clamp, parameterized for output width 8 or 4. It is instantiated three times: INT8, INT4-hi and INT4-lo. The top module muxes between them by mode.

## Test plan
- INT8 passthrough: scale=1, shift=0, zp=0, acc={5, −3, 200, −200}, ready=1.
  - `o_data` 5, −3, 127, −128 in T+3..T+6.
  - `o_col_idx` 0..3; `o_last` on the 4th beat; `o_done` in T+7; `o_clear_acc` only in T+1.
- Rounding: scale=3, shift=4, zp=10, acc={300, −300, 0, 16}.
  - Outputs 66, −46, 10, 13.
- INT4 packing: scale=1, shift=0, zp=0.
  - acc = {hi 5, lo −3} → 0x5D.
  - acc = {hi 100, lo −100} → 0x78.
- Backpressure: drop `i_ready` for 3 cycles at beat 1.
  - Beat 1's data and index are held unchanged while ready is low.
  - All 4 beats arrive in order; `o_done` follows last acceptance.
- Start while busy: pulse `i_start` mid-DRAIN.
  - Ignored; no second `o_clear_acc`; exactly 4 beats.
- Reset mid-drain: assert reset during beat 2.
  - All outputs at reset values next cycle; no `o_done`.
  - A fresh `i_start` drains a new row correctly.
